uart_tx_16x: RTL and testbench
==============================

UART_TX_16X -- requirements
Module: uart_tx_16x

Interface
REQ-001 Parameter DBIT, default 8: number of data bits per frame, legal range 5..8.
REQ-002 Parameter SB_TICK, default 16: stop-bit length in s_tick units (16/24/32 = 1/1.5/2 stop bits).
REQ-003 clk  input  1  single system clock, 50 MHz nominal, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_tick  input  1  one-clk-wide 16x-oversampling enable, driven by binary_16b_counter max_tick (max_count=163 at 50 MHz for 19200 baud).
REQ-006 tx_start  input  1  request to send din; sampled only in IDLE.
REQ-007 din  input  8  byte to transmit; bits [DBIT-1:0] used, LSB first.
REQ-008 tx  output  1  serial line, registered, idle-high.
REQ-009 busy  output  1  high whenever state != IDLE.
REQ-010 tx_done_tick  output  1  one-clk pulse at frame end.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP; 4-bit s counter (ticks within bit), 3-bit n counter (bit index), DBIT-wide shift register b.
REQ-012 IDLE: tx=1; on tx_start=1 SHALL load b<=din, s<=0, go START; tx low on the next clk edge (latency 1 clk).
REQ-013 START: tx=0; on s_tick, s==15 -> s<=0, n<=0, go DATA; else s<=s+1.
REQ-014 DATA: tx=b[0]; on s_tick, s==15 -> s<=0, b<=b>>1, then n==DBIT-1 -> go STOP else n<=n+1; else s<=s+1.
REQ-015 STOP: tx=1; on s_tick, s==SB_TICK-1 -> go IDLE with tx_done_tick=1 for exactly one clk; else s<=s+1. s SHALL be sized to hold SB_TICK-1.
REQ-016 Each bit SHALL last exactly 16 s_ticks (stop: SB_TICK); no state change occurs in a cycle without s_tick except IDLE->START.
REQ-017 tx_start while busy=1 SHALL be ignored; din changes while busy SHALL not affect the frame in flight.
REQ-018 tx_start in the same clk that tx_done_tick is high SHALL be accepted (state is IDLE then), allowing back-to-back frames with zero idle gap.
REQ-019 s_tick coincident with tx_start in IDLE SHALL not count toward START.
REQ-020 Counters SHALL wrap only by explicit reset to 0 per REQ-013..015; no free-running overflow.

Reset
REQ-021 reset=1 SHALL, at the next clk edge, force state=IDLE, s=0, n=0, b=0, tx=1, busy=0, tx_done_tick=0, overriding all other inputs.
REQ-022 reset asserted mid-frame SHALL abort the frame with no tx_done_tick; tx returns high on the next edge.

Structure
REQ-023 Shared package uart_pkg SHALL hold the state encoding and constants OVERSAMPLE=16, DEF_DBIT=8, DEF_SB_TICK=16, BAUD_19200_MAX_COUNT=163.
REQ-024 No sub-module inside uart_tx_16x; the tick source binary_16b_counter is instantiated beside it at the next level up.

Verification
REQ-025 Reset held 100 ns, then released -> tx=1, busy=0, tx_done_tick=0 for 1000 clks with no tx_start.
REQ-026 s_tick from binary_16b_counter (max_count=163), din=0x55, one-clk tx_start -> tx sequence 0,1,0,1,0,1,0,1,0,1 each 16 ticks (16*164 clks), one tx_done_tick, busy low after 160 ticks.
REQ-027 din=0xA3 then tx_start pulsed again at bit 4 with din=0xFF -> only 0xA3 (bits 1,1,0,0,0,1,0,1) on tx, one tx_done_tick.
REQ-028 tx_start held high continuously with din=0x00 -> back-to-back frames, stop bit directly followed by start bit, one tx_done_tick per frame.
REQ-029 reset asserted during DATA bit 3 of 0x0F -> tx=1 next clk, busy=0, no tx_done_tick; subsequent 0x81 frame correct.
REQ-030 SB_TICK=32 instance, din=0x00 -> stop bit high for exactly 32 s_ticks before tx_done_tick.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, oversampling constants, counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   localparam int OVERSAMPLE           = 16;
   localparam int DEF_DBIT             = 8;
   localparam int DEF_SB_TICK          = 16;
   localparam int BAUD_19200_MAX_COUNT = 163;

   // Tick-counter width: wide enough for a full data bit (OVERSAMPLE-1)
   // and for the longest configured stop bit (sb_tick-1).
   function automatic int s_width(input int sb_tick);
      return (sb_tick > OVERSAMPLE) ? $clog2(sb_tick) : $clog2(OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_tx_16x.sv
// UART transmitter driven by a 16x oversampling tick; frames start bit, DBIT data bits LSB first, stop bit.
// Latency: tx falls one clk after tx_start is sampled in IDLE; each bit lasts 16 s_ticks (stop: SB_TICK).
// Backpressure: busy high while a frame is in flight; tx_start is ignored until busy drops.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset, aborts any frame in flight
//   s_tick       one-clk 16x oversampling enable
//   tx_start     send request, sampled only in IDLE
//   din          data byte, bits [DBIT-1:0] transmitted LSB first
//   tx           registered serial line, idle high
//   busy         high whenever the FSM is not in IDLE
//   tx_done_tick one-clk pulse when the stop bit completes
module uart_tx_16x
   import uart_pkg::*;
#(
   parameter int DBIT    = DEF_DBIT,
   parameter int SB_TICK = DEF_SB_TICK
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_tick,
   input  logic       tx_start,
   input  logic [7:0] din,
   output logic       tx,
   output logic       busy,
   output logic       tx_done_tick
);

   localparam int SW = s_width(SB_TICK);

   localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
   localparam logic [2:0]    N_LAST      = 3'(DBIT - 1);

   tx_state_e       state_q;
   logic [SW-1:0]   s_q;
   logic [SW-1:0]   s_d;
   logic [2:0]      n_q;
   logic [DBIT-1:0] b_q;
   logic            tx_q;
   logic            done_q;

   assign s_d = s_q + SW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               tx_q <= 1'b1;
               // A coincident s_tick is deliberately not counted: s starts at 0.
               if (tx_start) begin
                  b_q     <= din[DBIT-1:0];
                  s_q     <= '0;
                  tx_q    <= 1'b0;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (s_tick) begin
                  if (s_q == S_BIT_LAST) begin
                     s_q     <= '0;
                     n_q     <= '0;
                     tx_q    <= b_q[0];
                     state_q <= ST_DATA;
                  end else begin
                     s_q <= s_d;
                  end
               end
            end
            ST_DATA: begin
               if (s_tick) begin
                  if (s_q == S_BIT_LAST) begin
                     s_q <= '0;
                     b_q <= b_q >> 1;
                     if (n_q == N_LAST) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                     end else begin
                        // b_q[1] is the bit that lands in b_q[0] after this shift.
                        tx_q <= b_q[1];
                        n_q  <= n_q + 3'd1;
                     end
                  end else begin
                     s_q <= s_d;
                  end
               end
            end
            ST_STOP: begin
               if (s_tick) begin
                  if (s_q == S_STOP_LAST) begin
                     s_q     <= '0;
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end else begin
                     s_q <= s_d;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   assign tx           = tx_q;
   assign busy         = (state_q != ST_IDLE);
   assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_16x.sv
// Bench for uart_tx_16x: two instances (1 and 2 stop bits) checked each cycle against a tick-count frame model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_16x;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       s_tick   = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] din      = 8'h00;

   logic tx0, busy0, done0;
   logic tx1, busy1, done1;

   int cmp_n    = 0;
   int err_n    = 0;
   int ticks    = 0;
   int tick_cnt = 0;
   int tick_div = 3;

   always #10 clk = ~clk;

   uart_tx_16x #(.DBIT(8), .SB_TICK(16)) dut0 (
      .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
      .tx(tx0), .busy(busy0), .tx_done_tick(done0)
   );

   uart_tx_16x #(.DBIT(8), .SB_TICK(32)) dut1 (
      .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
      .tx(tx1), .busy(busy1), .tx_done_tick(done1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmp_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One clock: advance to the falling edge, count the tick consumed by the
   // rising edge just passed, then drive the next s_tick.
   task automatic cyc();
      @(negedge clk);
      if (s_tick) ticks++;
      tick_cnt++;
      if (tick_cnt >= tick_div) begin
         tick_cnt = 0;
         s_tick   = 1'b1;
      end else begin
         s_tick = 1'b0;
      end
   endtask

   // ---------------- reference model ----------------
   // A frame is a run of ticks counted from acceptance: 16 start ticks,
   // 16 per data bit, then the stop ticks; done fires when the count reaches the total.
   localparam int TOT0 = 16 * 9 + 16;
   localparam int TOT1 = 16 * 9 + 32;

   logic       m_act [2];
   int         m_k   [2];
   logic [7:0] m_b   [2];
   logic       m_done[2];
   logic       m_tx  [2];
   bit         m_ok = 1'b0;

   function automatic logic lvl(input int k, input logic [7:0] b);
      if (k < 16)  return 1'b0;
      if (k < 144) return b[(k - 16) / 16];
      return 1'b1;
   endfunction

   initial begin : model
      logic       r, st, ts;
      logic [7:0] d;
      int         tot;
      forever begin
         @(posedge clk);
         r  = reset;
         st = s_tick;
         ts = tx_start;
         d  = din;
         #5;
         for (int i = 0; i < 2; i++) begin
            tot       = (i == 0) ? TOT0 : TOT1;
            m_done[i] = 1'b0;
            if (r) begin
               m_act[i] = 1'b0;
            end else if (!m_act[i]) begin
               if (ts) begin
                  m_act[i] = 1'b1;
                  m_k[i]   = 0;
                  m_b[i]   = d;
               end
            end else if (st) begin
               m_k[i]++;
               if (m_k[i] == tot) begin
                  m_act[i]  = 1'b0;
                  m_done[i] = 1'b1;
               end
            end
            m_tx[i] = m_act[i] ? lvl(m_k[i], m_b[i]) : 1'b1;
         end
         if (r) m_ok = 1'b1;
         if (m_ok) begin
            chk("model_tx0",   tx0,   m_tx[0]);
            chk("model_busy0", busy0, m_act[0]);
            chk("model_done0", done0, m_done[0]);
            chk("model_tx1",   tx1,   m_tx[1]);
            chk("model_busy1", busy1, m_act[1]);
            chk("model_done1", done1, m_done[1]);
         end
      end
   end

   // ---------------- stimulus ----------------
   // Sends one frame and watches it to completion. cap[j] is dut0's line at the
   // middle of bit slot j (0 = start, 1..8 data, 9 stop). at0/at1 give the tick
   // count at which each done pulse appeared (-1 if none).
   task automatic send(input logic [7:0] d, input bit mid_pulse, input logic [7:0] d2,
                       input int abort_at, output logic [9:0] cap,
                       output int nd0, output int nd1, output int at0, output int at1);
      cap = '0; nd0 = 0; nd1 = 0; at0 = -1; at1 = -1;
      cyc();
      tx_start = 1'b1;
      din      = d;
      cyc();
      tx_start = 1'b0;
      din      = 8'($urandom);
      ticks    = 0;
      for (int c = 0; c < 40000; c++) begin
         cyc();
         tx_start = 1'b0;
         if (done0) begin nd0++; if (at0 < 0) at0 = ticks; end
         if (done1) begin nd1++; if (at1 < 0) at1 = ticks; end
         if ((ticks % 16) == 8 && (ticks / 16) < 10) cap[ticks / 16] = tx0;
         if (mid_pulse && ticks == 16 * 5 + 4) begin
            tx_start = 1'b1;
            din      = d2;
         end
         if (abort_at > 0 && ticks == abort_at) begin
            reset = 1'b1;
            cyc();
            reset = 1'b0;
            chk("abort_tx",   tx0,   1'b1);
            chk("abort_busy", busy0, 1'b0);
            chk("abort_done", done0, 1'b0);
            for (int k = 0; k < 400; k++) begin
               cyc();
               if (done0) nd0++;
               if (done1) nd1++;
            end
            break;
         end
         if (at0 >= 0 && at1 >= 0 && !busy0 && !busy1) break;
      end
   endtask

   initial begin : main
      logic [9:0] cap;
      int         nd0, nd1, at0, at1;
      bit         bad, gap_chk;

      // Reset held 100 ns, then a long quiet idle.
      repeat (5) cyc();
      reset = 1'b0;
      cyc();
      chk("rst_tx",   tx0,   1'b1);
      chk("rst_busy", busy0, 1'b0);
      chk("rst_done", done0, 1'b0);
      bad = 1'b0;
      repeat (1000) begin
         cyc();
         if (!tx0 || busy0 || done0 || !tx1 || busy1 || done1) bad = 1'b1;
      end
      chk("idle_quiet", bad, 1'b0);

      // 0x55 at the 19200-baud tick rate (one tick every 164 clks).
      tick_div = 164;
      send(8'h55, 1'b0, 8'h00, 0, cap, nd0, nd1, at0, at1);
      chk("f55_bits",  cap, 10'b1010101010);
      chk("f55_done0", nd0, 1);
      chk("f55_at0",   at0, 160);
      chk("f55_done1", nd1, 1);
      chk("f55_at1",   at1, 176);

      // 0xA3 with a second request (0xFF) during data bit 4.
      tick_div = 3;
      send(8'hA3, 1'b1, 8'hFF, 0, cap, nd0, nd1, at0, at1);
      chk("fA3_bits",  cap, 10'b1101000110);
      chk("fA3_done0", nd0, 1);
      chk("fA3_at0",   at0, 160);

      // Reset during data bit 3 of 0x0F, then a clean 0x81.
      send(8'h0F, 1'b0, 8'h00, 16 * 4 + 4, cap, nd0, nd1, at0, at1);
      chk("abort_nodone0", nd0, 0);
      chk("abort_nodone1", nd1, 0);
      send(8'h81, 1'b0, 8'h00, 0, cap, nd0, nd1, at0, at1);
      chk("f81_bits",  cap, 10'b1100000010);
      chk("f81_done0", nd0, 1);
      chk("f81_at0",   at0, 160);

      // tx_start held high: start bit must follow the done pulse directly.
      tick_div = 2;
      nd0 = 0; nd1 = 0; gap_chk = 1'b0;
      tx_start = 1'b1;
      din      = 8'h00;
      for (int c = 0; c < 1150; c++) begin
         cyc();
         if (gap_chk) begin
            chk("b2b_start_tx", tx0,   1'b0);
            chk("b2b_busy",     busy0, 1'b1);
            gap_chk = 1'b0;
         end
         if (done0) begin nd0++; gap_chk = 1'b1; end
         if (done1) nd1++;
      end
      tx_start = 1'b0;
      chk("b2b_frames0", nd0, 3);
      chk("b2b_frames1", nd1, 3);
      for (int c = 0; c < 3000; c++) begin
         cyc();
         if (!busy0 && !busy1) break;
      end
      chk("b2b_drained", busy0 | busy1, 1'b0);

      // Random frames, tick rates, stray requests and idle gaps.
      repeat (15) begin
         tick_div = $urandom_range(2, 4);
         send(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 0, cap, nd0, nd1, at0, at1);
         chk("rnd_done0", nd0, 1);
         chk("rnd_at0",   at0, 160);
         chk("rnd_at1",   at1, 176);
         repeat ($urandom_range(0, 5)) cyc();
      end

      repeat (4) cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
